// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared definitions for the multicycle main control FSM:
//                state encoding, datapath select codes, VMUL opcode and the
//                packed control bundle passed from the output decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // 4-bit state encoding; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_VMULS  = 4'd10,
    S_VMULW  = 4'd11
  } state_t;

  // ALU A operand select
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Funct[4:1] code identifying VMUL within Op=11
  localparam logic [3:0] VMUL_FUNCT = 4'b0000;

  // Control lines produced for one state
  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       vmul_start;
  } ctrl_t;

  // True when the instruction class/function select the vector multiply
  function automatic logic is_vmul(input logic [1:0] op, input logic [3:0] funct_41);
    return (op == 2'b11) && (funct_41 == VMUL_FUNCT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_fsm_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mc_fsm_outdec
//  Description : Combinational state-to-controls decoder for mc_mainfsm.
//                Pure Moore decode except FETCH IRWrite/NextPC, which follow
//                mem_ready. VMULS/VMULW decode only exists when
//                MC_MAINFSM_VEC_MUL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_fsm_outdec
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  // Decode the current state into datapath selects and strobes
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.adrsrc    = 1'b0;
        o_ctrl.alusrca   = SRCA_PC;
        o_ctrl.alusrcb   = SRCB_FOUR;
        o_ctrl.resultsrc = RES_ALU;
        o_ctrl.irwrite   = i_mem_ready;
        o_ctrl.nextpc    = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alusrca   = SRCA_PC;
        o_ctrl.alusrcb   = SRCB_FOUR;
        o_ctrl.resultsrc = RES_ALU;
      end
      S_MEMADR: begin
        o_ctrl.alusrca   = SRCA_REG;
        o_ctrl.alusrcb   = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.resultsrc = RES_DATA;
        o_ctrl.regw      = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.adrsrc    = 1'b1;
        o_ctrl.memw      = 1'b1;
      end
      S_EXECR: begin
        o_ctrl.alusrca   = SRCA_REG;
        o_ctrl.alusrcb   = SRCB_REG;
        o_ctrl.aluop     = 1'b1;
      end
      S_EXECI: begin
        o_ctrl.alusrca   = SRCA_REG;
        o_ctrl.alusrcb   = SRCB_IMM;
        o_ctrl.aluop     = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.resultsrc = RES_ALUOUT;
        o_ctrl.regw      = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca   = SRCA_REG;
        o_ctrl.alusrcb   = SRCB_IMM;
        o_ctrl.resultsrc = RES_ALU;
        o_ctrl.branch    = 1'b1;
      end
`ifdef MC_MAINFSM_VEC_MUL_EN
      S_VMULS: begin
        o_ctrl.vmul_start = 1'b1;
        o_ctrl.aluop      = 1'b1;
      end
      S_VMULW: begin
        o_ctrl.aluop      = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_mainfsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_mainfsm
//  Description : Main control FSM of the multicycle processor. Sequences
//                fetch / decode / execute / writeback across the shared ALU,
//                register file, memory port and IR, with a mem_ready
//                handshake for variable memory latency.
//  Config      : MC_MAINFSM_VEC_MUL_EN - enables the VMULS/VMULW path for
//                the multi-cycle vector multiplier (vmul_start/vmul_done).
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  input  logic       vmul_done,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       vmul_start,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

`ifndef MC_MAINFSM_VEC_MUL_EN
  // Multiplier handshake and VMUL function bits have no effect in this build
  logic w_unused_vmul;
  assign w_unused_vmul = ^{vmul_done, Funct[4:1]};
`endif

  // State register; reset drops straight back to FETCH, abandoning any access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection from Op/Funct and the memory/multiplier handshakes
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          default: w_next = S_EXECR;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
`ifdef MC_MAINFSM_VEC_MUL_EN
      S_EXECR:  w_next = is_vmul(Op, Funct[4:1]) ? S_VMULS : S_ALUWB;
      S_VMULS:  w_next = S_VMULW;
      S_VMULW:  w_next = vmul_done ? S_ALUWB : S_VMULW;
`else
      S_EXECR:  w_next = S_ALUWB;
`endif
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_fsm_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Strobes are squashed while reset is held so no write or PC update can
  // leak out during the asynchronous return to FETCH; selects pass through.
  assign IRWrite    = w_ctrl.irwrite    & reset;
  assign NextPC     = w_ctrl.nextpc     & reset;
  assign RegW       = w_ctrl.regw       & reset;
  assign MemW       = w_ctrl.memw       & reset;
  assign Branch     = w_ctrl.branch     & reset;
  assign vmul_start = w_ctrl.vmul_start & reset;
  assign AdrSrc     = w_ctrl.adrsrc;
  assign ALUSrcA    = w_ctrl.alusrca;
  assign ALUSrcB    = w_ctrl.alusrcb;
  assign ResultSrc  = w_ctrl.resultsrc;
  assign ALUOp      = w_ctrl.aluop;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_mainfsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_mainfsm
//  Description : Self-checking bench for mc_mainfsm. Instructions are planned
//                cycle by cycle from the instruction-class rules; each planned
//                cycle pushes its expected controls into a scoreboard that a
//                negedge monitor drains and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_mainfsm;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       vmul_done;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp, vmul_start;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       rw;
    logic       mw;
    logic       br;
    logic       aop;
    logic       vs;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mc_mainfsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .vmul_done  (vmul_done),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .ALUOp      (ALUOp),
    .vmul_start (vmul_start),
    .state      (state)
  );

  // Expected controls for a step, written from the step descriptions
  function automatic exp_t expect_of(input state_t s, input logic mr);
    exp_t e;
    e    = '0;
    e.st = s;
    case (s)
      S_FETCH:  begin e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.npc = mr; end
      S_DECODE: begin e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; end
      S_MEMADR: begin e.sb = 2'b01; end
      S_MEMRD:  begin e.adr = 1'b1; end
      S_MEMWB:  begin e.rs = 2'b01; e.rw = 1'b1; end
      S_MEMWR:  begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXECR:  begin e.aop = 1'b1; end
      S_EXECI:  begin e.sb = 2'b01; e.aop = 1'b1; end
      S_ALUWB:  begin e.rw = 1'b1; end
      S_BRANCH: begin e.sb = 2'b01; e.rs = 2'b10; e.br = 1'b1; end
      S_VMULS:  begin e.vs = 1'b1; e.aop = 1'b1; end
      S_VMULW:  begin e.aop = 1'b1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Directed comparison used outside the scoreboard flow
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // One planned cycle: drive inputs, queue expectation, advance to next cycle
  task automatic cyc(input state_t s, input logic mr, input logic vd);
    mem_ready = mr;
    vmul_done = vd;
    sb_q.push_back(expect_of(s, mr));
    @(posedge clk);
    #1;
  endtask

  // Plan one instruction: fw fetch waits, mw memory waits, n multiplier cycles
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fw, input int mw, input int n);
    Op    = op;
    Funct = funct;
    repeat (fw) cyc(S_FETCH, 1'b0, rb());
    cyc(S_FETCH, 1'b1, rb());
    cyc(S_DECODE, rb(), rb());
    if (op == 2'b01) begin
      cyc(S_MEMADR, rb(), rb());
      if (funct[0]) begin
        repeat (mw) cyc(S_MEMRD, 1'b0, rb());
        cyc(S_MEMRD, 1'b1, rb());
        cyc(S_MEMWB, rb(), rb());
      end else begin
        repeat (mw) cyc(S_MEMWR, 1'b0, rb());
        cyc(S_MEMWR, 1'b1, rb());
      end
    end else if (op == 2'b10) begin
      cyc(S_BRANCH, rb(), rb());
    end else if (op == 2'b00 && funct[5]) begin
      cyc(S_EXECI, rb(), rb());
      cyc(S_ALUWB, rb(), rb());
    end else begin
      cyc(S_EXECR, rb(), rb());
`ifdef MC_MAINFSM_VEC_MUL_EN
      if (op == 2'b11 && funct[4:1] == 4'b0000) begin
        cyc(S_VMULS, rb(), rb());
        repeat (n) cyc(S_VMULW, rb(), 1'b0);
        cyc(S_VMULW, rb(), 1'b1);
      end
`else
      if (n < 0) $display("negative multiplier latency ignored");
`endif
      cyc(S_ALUWB, rb(), rb());
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      a = {state, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           RegW, MemW, Branch, ALUOp, vmul_start};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_ctrl: got st=%0d ctl=%b expected st=%0d ctl=%b at %0t",
                 a.st, a[13:0], e.st, e[13:0], $time);
      end
    end
  end

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    reset     = 1'b0;
    Op        = 2'b00;
    Funct     = 6'd0;
    mem_ready = 1'b1;
    vmul_done = 1'b0;

    // Reset state: FETCH, strobes low even with mem_ready high
    #2;
    check("rst_state",   state,   4'(S_FETCH));
    check("rst_irwrite", {3'b0, IRWrite}, 4'd0);
    check("rst_nextpc",  {3'b0, NextPC},  4'd0);
    check("rst_srcb",    {2'b0, ALUSrcB}, 4'b0010);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rel_irwrite", {3'b0, IRWrite}, 4'd1);

    // Store, then reset while MemW is asserted in MEMWR
    Op    = 2'b01;
    Funct = 6'b000000;
    @(posedge clk); #1;
    check("str_decode", state, 4'(S_DECODE));
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("str_memwr", state, 4'(S_MEMWR));
    check("str_memw",  {3'b0, MemW}, 4'd1);
    #2;
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("arst_state",  state, 4'(S_FETCH));
    check("arst_memw",   {3'b0, MemW},    4'd0);
    check("arst_nextpc", {3'b0, NextPC},  4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold", state, 4'(S_FETCH));
    reset = 1'b1;
    #1;
    check("arel_irwrite", {3'b0, IRWrite}, 4'd1);
    mem_ready = 1'b0;
    @(posedge clk); #1;

    // Directed instruction flows
    run_instr(2'b00, 6'b001000, 0, 0, 0);   // ADD reg
    run_instr(2'b01, 6'b000001, 0, 2, 0);   // LDR, two MEMRD waits
    run_instr(2'b01, 6'b000000, 0, 3, 0);   // STR, three MEMWR waits
    run_instr(2'b10, 6'b000000, 0, 0, 0);   // branch
    run_instr(2'b11, 6'b000000, 0, 0, 3);   // VMUL, done after 3 cycles
    run_instr(2'b11, 6'b100001, 1, 0, 0);   // VMUL, done at once
    run_instr(2'b00, 6'b100000, 2, 0, 0);   // immediate data-processing
    run_instr(2'b11, 6'b000110, 0, 0, 2);   // Op=11 non-VMUL

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if (op == 2'b11 && $urandom_range(0, 1) == 1) f[4:1] = 4'b0000;
      run_instr(op, f, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_mainfsm.md
# mc_mainfsm

Main control FSM for the multicycle version of the processor. It sequences the shared ALU, register file, memory port and instruction register across FETCH/DECODE/EXECUTE/WRITEBACK steps, driving the datapath select and strobe lines from `Op`/`Funct`. It handles variable memory latency through a ready handshake and, optionally, a multi-cycle vector multiplier. It sits beside the instruction decoder and condition logic; conditional gating of `RegW`/`MemW` stays in the condition logic.

## Interface
- No parameters. State encoding constants come from the shared package.
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `Op` in 2: instruction class from the IR.
- `Funct` in 6: instruction function field from the IR.
- `mem_ready` in 1: memory port completes the current access this cycle.
- `vmul_done` in 1: vector multiplier result valid (only with `VEC_MUL_EN`).
- `IRWrite` out 1: load the instruction register.
- `NextPC` out 1: write the PC.
- `AdrSrc` out 1: memory address select (0 = PC, 1 = ALU result register).
- `ALUSrcA` out 2: ALU A operand select.
- `ALUSrcB` out 2: ALU B operand select.
- `ResultSrc` out 2: result bus select.
- `RegW` out 1: register-file write (before condition gating).
- `MemW` out 1: memory write.
- `Branch` out 1: branch step.
- `ALUOp` out 1: ALU uses decoded `Funct`; 0 forces add.
- `vmul_start` out 1: one-cycle multiplier start pulse.
- `state` out 4: current state, for debug and bench.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VMULS, VMULW.
- FETCH: `AdrSrc`=0, `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10, `ALUOp`=0.
  - Hold while `mem_ready`=0.
  - When `mem_ready`=1: `IRWrite`=`NextPC`=1 for that cycle, then go to DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10.
  - `Op`=01 goes to MEMADR.
  - `Op`=10 goes to BRANCH.
  - `Op`=00 with `Funct[5]`=1 goes to EXECI.
  - `Op`=00 with `Funct[5]`=0 goes to EXECR.
  - `Op`=11 goes to EXECR.
- MEMADR: `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=0. Go to MEMRD if `Funct[0]`=1, else MEMWR.
- MEMRD: `AdrSrc`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `ResultSrc`=01, `RegW`=1, then go to FETCH.
- MEMWR: `AdrSrc`=1, `MemW`=1 every cycle in the state. Leave to FETCH on `mem_ready`.
- EXECR: `ALUSrcA`=00, `ALUSrcB`=00, `ALUOp`=1.
  - Go to VMULS if the instruction is VMUL (`Op`=11 and `Funct[4:1]`=0000) and `VEC_MUL_EN` is defined.
  - Otherwise go to ALUWB.
- EXECI: `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=1, then go to ALUWB.
- ALUWB: `ResultSrc`=00, `RegW`=1, then go to FETCH.
- BRANCH: `ALUSrcA`=00, `ALUSrcB`=01, `ResultSrc`=10, `Branch`=1, then go to FETCH.
- VMULS: `vmul_start`=1, `ALUOp`=1, then go to VMULW. `vmul_done` is ignored in this state.
- VMULW: `ALUOp`=1. Hold until `vmul_done`, then go to ALUWB.
- Unlisted outputs are 0 in every state.
- Illegal or unused state codes go to FETCH on the next edge with all strobes 0.

## Timing
- Reset asserted: `state`=FETCH immediately, asynchronously.
  - All strobes are forced to 0: `IRWrite`, `NextPC`, `RegW`, `MemW`, `Branch`, `vmul_start`.
  - Selects take their FETCH values.
- Reset release: the first FETCH completes on the first edge with `mem_ready`=1.
- Outputs are Moore decodes of `state`. The only exception is FETCH `IRWrite`/`NextPC`, which are ANDed with `mem_ready`.
- Cycle counts with `mem_ready` always 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - VMUL: 6 + N cycles, where `vmul_done` rises N cycles after entering VMULW.
- Each memory wait cycle adds exactly one cycle. No strobe repeats during a wait, except `MemW`, which is held.
- Reset mid-instruction abandons the instruction with no pending write. The PC is not advanced.

## Configuration
- `MC_MAINFSM_VEC_MUL_EN` defined: VMUL takes the VMULS/VMULW path, and `vmul_done` is honoured.
- Not defined:
  - VMUL behaves like any EXECR op (straight to ALUWB).
  - VMULS/VMULW are not generated.
  - `vmul_start` is tied to 0 and `vmul_done` is unused.

## Structure
- Shared package `mc_pkg` holds:
  - the 4-bit state encoding constants;
  - select-code constants: `SRCA_*`, `SRCB_*`, `RES_*`;
  - the VMUL `Funct[4:1]` opcode constant.
- One sub-module, `mc_fsm_outdec`: a combinational state-to-controls decoder. It keeps the next-state register logic in `mc_mainfsm` small.

## Test plan
- Reset low mid-MEMWR, held 2 cycles: `state`=FETCH asynchronously, `MemW`=0 immediately. After release with `mem_ready`=1, `IRWrite`=1 in the first cycle.
- ADD reg (`Op`=00, `Funct`=001000), `mem_ready`=1: states FETCH→DECODE→EXECR→ALUWB. `RegW`=1 only in cycle 4; `ALUOp`=1 in cycle 3.
- LDR (`Op`=01, `Funct[0]`=1), `mem_ready` low for 2 cycles in MEMRD: 7 cycles total. `AdrSrc`=1 through MEMRD; `RegW` is a single pulse in MEMWB.
- STR, `mem_ready` low for 3 cycles: `MemW` held high 4 cycles, then FETCH.
- Branch (`Op`=10): `Branch`=1 exactly in cycle 3, back to FETCH in cycle 4.
- VMUL (`Op`=11, `Funct[4:1]`=0000) with the macro, `vmul_done` after 3 cycles: one `vmul_start` pulse, then ALUWB. Without the macro: 4-cycle flow and `vmul_start` always 0.
